// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-2 stream demultiplexer.
// Channel index type, default data width and statistics counter width.
package demux_pkg;

    localparam int DEMUX_WIDTH = 32;
    localparam int CNT_W       = 16;

    typedef logic ch_t;

    localparam ch_t CH0 = 1'b0;
    localparam ch_t CH1 = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, DEPTH entries (power of two), registered head, memories cleared on reset.
// Latency: a pushed word is visible at head one cycle after the push edge; no bypass.
// Backpressure: push ignored when full, pop ignored when empty; a pop never frees space for a same-cycle push.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/stream_demux_1to2.sv
// 1-to-2 stream demux: each word steered by in_sel into a per-channel FIFO. Optional DEMUX_STATS_EN adds cnt0/cnt1.
// Latency: one cycle from input acceptance to outK_valid; one word/cycle in, one word/cycle per channel out.
// Backpressure: in_ready = !full of the selected channel only; a stalled channel never blocks the other.
module stream_demux_1to2
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    logic full0, full1;
    logic empty0, empty1;
    logic push0, push1;
    logic pop0, pop1;

    // Only the targeted channel's fullness gates the producer.
    assign in_ready = (in_sel == CH1) ? !full1 : !full0;
    assign push0    = in_valid && in_ready && (in_sel == CH0);
    assign push1    = in_valid && in_ready && (in_sel == CH1);

    assign out0_valid = !empty0;
    assign out1_valid = !empty1;
    assign pop0       = out0_valid && out0_ready;
    assign pop1       = out1_valid && out1_ready;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push0),
        .push_data (in_data),
        .pop       (pop0),
        .full      (full0),
        .empty     (empty0),
        .head      (out0_data)
    );

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push1),
        .push_data (in_data),
        .pop       (pop1),
        .full      (full1),
        .empty     (empty1),
        .head      (out1_data)
    );

`ifdef DEMUX_STATS_EN
    // Delivered-word counters wrap naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (pop0) cnt0 <= cnt0 + CNT_W'(1);
            if (pop1) cnt1 <= cnt1 + CNT_W'(1);
        end
    end
`endif

endmodule
